or_share_arbiter: RTL and testbench



---
 rtl/or_share_arbiter_if.sv | 32 +++
 rtl/or_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_or_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/or_share_arbiter_if.sv
// Bus between the requesters, the shared 74x32 OR package and or_share_arbiter.
//   REQ        : per-requester request, bit i = requester i (level-sensitive)
//   A_IN/B_IN  : operands, requester i on bits [4i+3:4i]
//   OR_A/OR_B  : registered operands driven onto the shared gate
//   OR_Y       : combinational output of the shared gate
//   GNT/ACK    : one-hot grant / one-cycle one-hot completion pulse
//   Y/ID       : captured result and index of the requester it belongs to
//   BUSY       : arbiter is in a transaction
// The slave modport is the arbiter's view; master is the surrounding logic.
interface or_share_arbiter_if;
  logic [3:0]  REQ;
  logic [15:0] A_IN;
  logic [15:0] B_IN;
  logic [3:0]  OR_A;
  logic [3:0]  OR_B;
  logic [3:0]  OR_Y;
  logic [3:0]  GNT;
  logic [3:0]  ACK;
  logic [3:0]  Y;
  logic [1:0]  ID;
  logic        BUSY;

  modport slave (
    input  REQ, A_IN, B_IN, OR_Y,
    output OR_A, OR_B, GNT, ACK, Y, ID, BUSY
  );

  modport master (
    output REQ, A_IN, B_IN, OR_Y,
    input  OR_A, OR_B, GNT, ACK, Y, ID, BUSY
  );
endinterface

// File: rtl/or_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 4-bit OR gate among four
// requesters. The winner's operands are registered onto the gate, held for
// SETTLE cycles, then the gate output is captured into Y with a one-cycle ACK.
// Ports:
//   CLK    : system clock, rising edge
//   CLR_n  : asynchronous active-low reset
//   bus    : or_share_arbiter_if.slave (REQ, A_IN, B_IN, OR_Y in;
//            OR_A, OR_B, GNT, ACK, Y, ID, BUSY out)
// Parameter:
//   SETTLE : cycles operands are held on the gate before capture (1..15)
module or_share_arbiter #(
  parameter int SETTLE = 2
) (
  input  logic                  CLK,
  input  logic                  CLR_n,
  or_share_arbiter_if.slave     bus
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
    $error("or_share_arbiter: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] win_q,   win_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [3:0] ack_q,   ack_d;
  logic [3:0] or_a_q,  or_a_d;
  logic [3:0] or_b_q,  or_b_d;
  logic [3:0] y_q,     y_d;
  logic [1:0] id_q,    id_d;

  logic       win_valid;
  logic [1:0] win_sel;

  // Rotating priority: scan from the highest offset down so the lowest
  // offset from the pointer is the last (winning) assignment.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (bus.REQ[ptr_q + 2'(i)]) begin
        win_valid = 1'b1;
        win_sel   = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    or_a_d  = or_a_q;
    or_b_d  = or_b_q;
    y_d     = y_q;
    id_d    = id_q;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          win_d   = win_sel;
          gnt_d   = 4'b0001 << win_sel;
          // Operands are frozen here; later A_IN/B_IN changes are ignored.
          or_a_d  = bus.A_IN[{win_sel, 2'b00} +: 4];
          or_b_d  = bus.B_IN[{win_sel, 2'b00} +: 4];
          cnt_d   = SETTLE_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // REQ is not looked at: a dropped request still completes.
        if (cnt_q == 4'd0) begin
          y_d     = bus.OR_Y;
          id_d    = win_q;
          ack_d   = 4'b0001 << win_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        ack_d   = 4'b0000;
        gnt_d   = 4'b0000;
        ptr_d   = win_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state is plain registers, so the whole block clears on reset and an
  // aborted transaction can never produce an ACK afterwards.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      or_a_q  <= '0;
      or_b_q  <= '0;
      y_q     <= '0;
      id_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      or_a_q  <= or_a_d;
      or_b_q  <= or_b_d;
      y_q     <= y_d;
      id_q    <= id_d;
    end
  end

  assign bus.OR_A = or_a_q;
  assign bus.OR_B = or_b_q;
  assign bus.GNT  = gnt_q;
  assign bus.ACK  = ack_q;
  assign bus.Y    = y_q;
  assign bus.ID   = id_q;
  assign bus.BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_or_share_arbiter.sv
// Self-checking bench for or_share_arbiter: a directed vector table, hand
// sequences for arbitration order, fairness, reset abort and SETTLE=1/15, and
// a randomized run against a transaction-level reference model.
module tb_or_share_arbiter;

  localparam int S2 = 2;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  or_share_arbiter_if bus2 ();
  or_share_arbiter_if bus1 ();
  or_share_arbiter_if bus15 ();

  // The shared 74x32 modelled as a plain OR.
  assign bus2.OR_Y  = bus2.OR_A  | bus2.OR_B;
  assign bus1.OR_Y  = bus1.OR_A  | bus1.OR_B;
  assign bus15.OR_Y = bus15.OR_A | bus15.OR_B;

  or_share_arbiter #(.SETTLE(2))  dut2  (.CLK(clk), .CLR_n(clr_n), .bus(bus2));
  or_share_arbiter #(.SETTLE(1))  dut1  (.CLK(clk), .CLR_n(clr_n), .bus(bus1));
  or_share_arbiter #(.SETTLE(15)) dut15 (.CLK(clk), .CLR_n(clr_n), .bus(bus15));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] gnt, input logic [3:0] ack,
                            input logic [3:0] ora, input logic [3:0] orb, input logic [3:0] y,
                            input logic [1:0] id, input logic busy);
    check({tag, " GNT"},  bus2.GNT,  gnt);
    check({tag, " ACK"},  bus2.ACK,  ack);
    check({tag, " OR_A"}, bus2.OR_A, ora);
    check({tag, " OR_B"}, bus2.OR_B, orb);
    check({tag, " Y"},    bus2.Y,    y);
    check({tag, " ID"},   bus2.ID,   id);
    check({tag, " BUSY"}, bus2.BUSY, busy);
  endtask

  // ---------------- transaction-level reference model (SETTLE=2) ----------
  // A transaction is described by its age in cycles since the grant edge:
  // result due at age SETTLE, released at age SETTLE+1.
  bit         m_in_txn;
  int         m_age, m_win, m_p;
  logic [3:0] m_opa, m_opb, m_y;
  logic [1:0] m_id;

  function automatic void model_reset();
    m_in_txn = 0; m_age = 0; m_win = 0; m_p = 0;
    m_opa = '0; m_opb = '0; m_y = '0; m_id = '0;
  endfunction

  function automatic void model_step(input logic [3:0] req, input logic [15:0] a, input logic [15:0] b);
    bit found;
    if (m_in_txn) begin
      m_age++;
      if (m_age == S2) begin
        m_y  = m_opa | m_opb;
        m_id = 2'(m_win);
      end
      if (m_age == S2 + 1) begin
        m_in_txn = 0;
        m_p = (m_win + 1) % 4;
      end
    end else if (req != 4'h0) begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && req[(m_p + i) % 4]) begin
          found = 1;
          m_win = (m_p + i) % 4;
        end
      end
      m_in_txn = 1;
      m_age    = 0;
      m_opa    = 4'((a >> (4 * m_win)) & 16'hF);
      m_opb    = 4'((b >> (4 * m_win)) & 16'hF);
    end
  endfunction

  task automatic check_model(input string tag);
    logic [3:0] eg, ea;
    eg = m_in_txn ? 4'(1 << m_win) : 4'h0;
    ea = (m_in_txn && m_age == S2) ? 4'(1 << m_win) : 4'h0;
    check_outs(tag, eg, ea, m_opa, m_opb, m_y, m_id, m_in_txn);
  endtask

  // ---------------- helpers -------------------------------------------------
  task automatic do_reset();
    clr_n = 1'b0;
    bus2.REQ = '0;  bus2.A_IN = '0;  bus2.B_IN = '0;
    bus1.REQ = '0;  bus1.A_IN = '0;  bus1.B_IN = '0;
    bus15.REQ = '0; bus15.A_IN = '0; bus15.B_IN = '0;
    model_reset();
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  function automatic int low_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [3:0] p_gnt(input int w); return (w == 1) ? bus1.GNT  : bus15.GNT;  endfunction
  function automatic logic [3:0] p_ack(input int w); return (w == 1) ? bus1.ACK  : bus15.ACK;  endfunction
  function automatic logic [3:0] p_ora(input int w); return (w == 1) ? bus1.OR_A : bus15.OR_A; endfunction
  function automatic logic [3:0] p_orb(input int w); return (w == 1) ? bus1.OR_B : bus15.OR_B; endfunction
  function automatic logic [3:0] p_y  (input int w); return (w == 1) ? bus1.Y    : bus15.Y;    endfunction

  task automatic set_req(input int w, input logic [3:0] v);
    if (w == 1) bus1.REQ = v; else bus15.REQ = v;
  endtask

  task automatic set_ab(input int w, input logic [15:0] a, input logic [15:0] b);
    if (w == 1) begin bus1.A_IN = a; bus1.B_IN = b; end
    else begin bus15.A_IN = a; bus15.B_IN = b; end
  endtask

  // Grant-to-ACK latency and operand stability for one of the SETTLE builds.
  task automatic settle_probe(input int w, input int s);
    int g = -1;
    int a = -1;
    bit stable = 1;
    logic [3:0] ora0 = '0, orb0 = '0;
    set_req(w, 4'b0100);
    set_ab(w, 16'h0A00, 16'h0500);
    for (int c = 0; c < 40 && a < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (g < 0 && p_gnt(w) != 4'h0) begin
        g = c; ora0 = p_ora(w); orb0 = p_orb(w);
        set_req(w, 4'h0);
      end else if (g >= 0) begin
        if (p_ora(w) !== ora0 || p_orb(w) !== orb0) stable = 0;
      end
      if (p_ack(w) != 4'h0) a = c;
      if (g >= 0) set_ab(w, 16'($urandom), 16'($urandom));
    end
    check($sformatf("settle%0d grant-to-ack", s), 32'(a - g), 32'(s));
    check($sformatf("settle%0d operands stable", s), 32'(stable), 32'd1);
    check($sformatf("settle%0d OR_A at grant", s), ora0, 4'hA);
    check($sformatf("settle%0d Y", s), p_y(w), 4'hF);
  endtask

  // ---------------- directed vector table ------------------------------------
  typedef struct {
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [3:0]  or_a;
    logic [3:0]  or_b;
    logic [3:0]  y;
    logic [1:0]  id;
    logic        busy;
  } vec_t;

  vec_t vecs[8];
  int   q_idx[$];
  int   q_y[$];
  int   q_t[$];
  int   g_seq[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [3:0] prev;
    int found;

    // Single request then operand change after grant (requester 1, P=1).
    vecs[0] = '{4'b0001, 16'h000A, 16'h0005, 4'b0001, 4'b0000, 4'hA, 4'h5, 4'h0, 2'd0, 1'b1};
    vecs[1] = '{4'b0000, 16'h0000, 16'h0000, 4'b0001, 4'b0000, 4'hA, 4'h5, 4'h0, 2'd0, 1'b1};
    vecs[2] = '{4'b0000, 16'h0000, 16'h0000, 4'b0001, 4'b0001, 4'hA, 4'h5, 4'hF, 2'd0, 1'b1};
    vecs[3] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 4'hA, 4'h5, 4'hF, 2'd0, 1'b0};
    vecs[4] = '{4'b0010, 16'h0030, 16'h0040, 4'b0010, 4'b0000, 4'h3, 4'h4, 4'hF, 2'd0, 1'b1};
    vecs[5] = '{4'b0010, 16'h00C0, 16'h0040, 4'b0010, 4'b0000, 4'h3, 4'h4, 4'hF, 2'd0, 1'b1};
    vecs[6] = '{4'b0010, 16'h00C0, 16'h0040, 4'b0010, 4'b0010, 4'h3, 4'h4, 4'h7, 2'd1, 1'b1};
    vecs[7] = '{4'b0000, 16'h00C0, 16'h0040, 4'b0000, 4'b0000, 4'h3, 4'h4, 4'h7, 2'd1, 1'b0};

    do_reset();
    check_outs("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      bus2.REQ = vecs[i].req; bus2.A_IN = vecs[i].a_in; bus2.B_IN = vecs[i].b_in;
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].or_a,
                 vecs[i].or_b, vecs[i].y, vecs[i].id, vecs[i].busy);
    end

    // All four requesting continuously: ACK order 0,1,2,3,0 every 4 cycles.
    do_reset();
    bus2.REQ = 4'hF; bus2.A_IN = 16'h3210; bus2.B_IN = 16'h0000;
    for (int c = 0; c < 40 && q_idx.size() < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus2.ACK != 4'h0) begin
        q_idx.push_back(low_idx(bus2.ACK)); q_y.push_back(int'(bus2.Y)); q_t.push_back(c);
        check("all4 ACK one-hot", $countones(bus2.ACK), 1);
      end
    end
    check("all4 ACK count", q_idx.size(), 5);
    for (int i = 0; i < q_idx.size(); i++) begin
      check($sformatf("all4 ACK[%0d] idx", i), q_idx[i], i % 4);
      check($sformatf("all4 ACK[%0d] Y", i), q_y[i], i % 4);
      if (i > 0) check($sformatf("all4 ACK[%0d] spacing", i), q_t[i] - q_t[i-1], 4);
    end

    // Fairness: REQ=1010 held from reset alternates 1,3,1,3.
    do_reset();
    bus2.REQ = 4'b1010;
    prev = '0;
    for (int c = 0; c < 40 && g_seq.size() < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus2.GNT != 4'h0 && prev == 4'h0) g_seq.push_back(low_idx(bus2.GNT));
      prev = bus2.GNT;
    end
    check("fair grant count", g_seq.size(), 4);
    for (int i = 0; i < g_seq.size(); i++)
      check($sformatf("fair grant[%0d]", i), g_seq[i], (i % 2 == 0) ? 1 : 3);

    // Reset mid-WAIT: serve 0 (P=1), start requester 1, abort between edges 1 and 2.
    do_reset();
    bus2.REQ = 4'b0001; bus2.A_IN = 16'h0001; bus2.B_IN = 16'h0000;
    @(posedge clk); @(negedge clk);
    bus2.REQ = 4'b0000;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("abort pre idle", bus2.BUSY, 1'b0);
    bus2.REQ = 4'b0010; bus2.A_IN = 16'h00F0; bus2.B_IN = 16'h0030;
    @(posedge clk); @(negedge clk);
    check("abort granted", bus2.GNT, 4'b0010);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1 check_outs("abort async", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
    @(negedge clk); check("abort no ACK a", bus2.ACK, 4'h0);
    @(posedge clk); @(negedge clk); check("abort no ACK b", bus2.ACK, 4'h0);
    clr_n = 1'b1;
    bus2.REQ = 4'b0101;
    @(posedge clk); @(negedge clk);
    check("abort P=0 winner", bus2.GNT, 4'b0001);
    bus2.REQ = 4'b0000;
    for (int c = 0; c < 8 && bus2.BUSY; c++) begin @(posedge clk); @(negedge clk); end
    check("abort drain", bus2.BUSY, 1'b0);
    bus2.REQ = 4'b0100;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus2.ACK != 4'h0) begin
        found = 1;
        check("abort req2 ACK", bus2.ACK, 4'b0100);
        check("abort req2 ID", bus2.ID, 2'd2);
      end
    end
    check("abort req2 served", found, 1);

    // SETTLE=1 and SETTLE=15 builds.
    do_reset();
    settle_probe(1, 1);
    settle_probe(15, 15);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus2.REQ  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bus2.A_IN = 16'($urandom);
      bus2.B_IN = 16'($urandom);
      @(posedge clk);
      model_step(bus2.REQ, bus2.A_IN, bus2.B_IN);
      @(negedge clk);
      check_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
